nanoboot_image_loader: RTL and testbench

//  Sits downstream of the NanoFS wrapper. Fetches a boot image file word by word and validates its

---
 rtl/nanoboot_image_loader.sv | 168 ++++++++++++++++
 tb/tb_nanoboot_image_loader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nanoboot_image_loader.sv
// Boot image loader: pulls a NanoFS file word by word, checks magic/length/checksum,
// streams the payload into program memory and releases the CPU only on a valid image.
module nanoboot_image_loader #(
   parameter int             N           = 32,
   parameter int             ADDR_W      = 14,
   parameter int             BASE_ADDR   = 0,
   parameter logic [N-1:0]   MAGIC       = N'(32'h4E424F54),
   parameter logic [23:0]    TIMEOUT_CYC = 24'hFFFFFF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [2:0]        error_code,
   output logic [ADDR_W:0]   words_loaded,
   output logic              cpu_rst,
   output logic              fs_start,
   input  logic              fs_busy,
   input  logic [N-1:0]      fs_data,
   output logic              fs_next_data,
   input  logic              fs_eof,
   input  logic              fs_file_not_found,
   input  logic              fs_err,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [N-1:0]      mem_wdata
);

   typedef enum logic [2:0] {
      S_IDLE, S_LAUNCH, S_SETTLE, S_WAIT, S_CONSUME, S_REQ, S_DONE, S_FAIL
   } state_t;

   typedef enum logic [1:0] {W_MAGIC, W_LEN, W_PAYLOAD, W_SUM} word_kind_t;

   localparam logic [N-1:0]      MAX_LEN = N'(1) << ADDR_W;
   localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W:0]   ONE     = {{ADDR_W{1'b0}}, 1'b1};

   state_t          state;
   word_kind_t      phase;
   logic [N-1:0]    word;
   logic            eof_seen;
   logic [ADDR_W:0] length;
   logic [N-1:0]    checksum;
   logic [23:0]     timeout_cnt;

   // The word is latched in WAIT, so CONSUME works from a stable copy even if the wrapper moves on.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         phase        <= W_MAGIC;
         word         <= '0;
         eof_seen     <= 1'b0;
         length       <= '0;
         checksum     <= '0;
         timeout_cnt  <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         error_code   <= 3'd0;
         words_loaded <= '0;
         cpu_rst      <= 1'b1;
         fs_start     <= 1'b0;
         fs_next_data <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
      end else begin
         fs_start     <= 1'b0;
         fs_next_data <= 1'b0;
         mem_we       <= 1'b0;
         case (state)
            S_IDLE, S_DONE, S_FAIL: begin
               if (start) begin
                  state        <= S_LAUNCH;
                  phase        <= W_MAGIC;
                  busy         <= 1'b1;
                  done         <= 1'b0;
                  cpu_rst      <= 1'b1;
                  fs_start     <= 1'b1;
                  error_code   <= 3'd0;
                  words_loaded <= '0;
                  checksum     <= '0;
                  length       <= '0;
                  timeout_cnt  <= '0;
               end
            end
            default: begin
               // Wrapper failures take precedence over whatever word is in flight.
               if (fs_file_not_found) begin
                  state <= S_FAIL; busy <= 1'b0; error_code <= 3'd1;
               end else if (fs_err) begin
                  state <= S_FAIL; busy <= 1'b0; error_code <= 3'd2;
               end else begin
                  case (state)
                     S_LAUNCH: state <= S_SETTLE;
                     S_SETTLE: begin
                        timeout_cnt <= '0;
                        state       <= S_WAIT;
                     end
                     S_WAIT: begin
                        if (!fs_busy) begin
                           word     <= fs_data;
                           eof_seen <= fs_eof;
                           state    <= S_CONSUME;
                           if (phase == W_PAYLOAD) begin
                              mem_we    <= 1'b1;
                              mem_wdata <= fs_data;
                              mem_addr  <= BASE + words_loaded[ADDR_W-1:0];
                           end
                        end else if (timeout_cnt >= TIMEOUT_CYC - 24'd1) begin
                           state <= S_FAIL; busy <= 1'b0; error_code <= 3'd7;
                        end else begin
                           timeout_cnt <= timeout_cnt + 24'd1;
                        end
                     end
                     S_CONSUME: begin
                        case (phase)
                           W_MAGIC: begin
                              if (word != MAGIC) begin
                                 state <= S_FAIL; busy <= 1'b0; error_code <= 3'd3;
                              end else if (eof_seen) begin
                                 state <= S_FAIL; busy <= 1'b0; error_code <= 3'd5;
                              end else begin
                                 phase <= W_LEN; fs_next_data <= 1'b1; state <= S_REQ;
                              end
                           end
                           W_LEN: begin
                              if (word == '0 || word > MAX_LEN) begin
                                 state <= S_FAIL; busy <= 1'b0; error_code <= 3'd4;
                              end else if (eof_seen) begin
                                 state <= S_FAIL; busy <= 1'b0; error_code <= 3'd5;
                              end else begin
                                 length <= word[ADDR_W:0];
                                 phase  <= W_PAYLOAD; fs_next_data <= 1'b1; state <= S_REQ;
                              end
                           end
                           W_PAYLOAD: begin
                              checksum     <= checksum + word;
                              words_loaded <= words_loaded + ONE;
                              if (words_loaded + ONE == length) phase <= W_SUM;
                              if (eof_seen) begin
                                 state <= S_FAIL; busy <= 1'b0; error_code <= 3'd5;
                              end else begin
                                 fs_next_data <= 1'b1; state <= S_REQ;
                              end
                           end
                           W_SUM: begin
                              busy <= 1'b0;
                              if (word == checksum) begin
                                 state <= S_DONE; done <= 1'b1; cpu_rst <= 1'b0;
                              end else begin
                                 state <= S_FAIL; error_code <= 3'd6;
                              end
                           end
                           default: ;
                        endcase
                     end
                     S_REQ:   state <= S_SETTLE;
                     default: ;
                  endcase
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nanoboot_image_loader.sv
// Directed bench for nanoboot_image_loader: plays the NanoFS wrapper from a word table
// and checks status, error codes and the memory writes observed on the write port.
module tb_nanoboot_image_loader;

   localparam int          N         = 32;
   localparam int          ADDR_W    = 3;
   localparam int          BASE_ADDR = 2;
   localparam logic [31:0] MAGIC     = 32'h4E424F54;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              busy;
   logic              done;
   logic [2:0]        error_code;
   logic [ADDR_W:0]   words_loaded;
   logic              cpu_rst;
   logic              fs_start;
   logic              fs_busy;
   logic [N-1:0]      fs_data;
   logic              fs_next_data;
   logic              fs_eof;
   logic              fs_file_not_found;
   logic              fs_err;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [N-1:0]      mem_wdata;

   logic [31:0] image [0:15];
   logic [31:0] tb_mem [0:7];
   int          we_count = 0;
   int          we_base;
   int          total = 0;
   int          bad = 0;

   nanoboot_image_loader #(
      .N(N), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .MAGIC(MAGIC), .TIMEOUT_CYC(24'd16)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .error_code(error_code), .words_loaded(words_loaded), .cpu_rst(cpu_rst),
      .fs_start(fs_start), .fs_busy(fs_busy), .fs_data(fs_data),
      .fs_next_data(fs_next_data), .fs_eof(fs_eof),
      .fs_file_not_found(fs_file_not_found), .fs_err(fs_err),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata)
   );

   always #5 clk = ~clk;

   // Program memory stand-in: records every write strobe.
   always @(negedge clk) begin
      if (mem_we) begin
         tb_mem[mem_addr] <= mem_wdata;
         we_count         <= we_count + 1;
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Pulses start, then serves image[0..nwords-1] as the wrapper would; stops serving
   // (leaving fs_busy high) once present_n words have been handed over.
   task automatic applyStimulus(input int nwords, input int present_n, input int eof_at);
      int guard;
      start = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      fs_busy = 1'b1;
      fs_eof  = 1'b0;
      checkOutput("fs_start_pulse", fs_start, 1);
      checkOutput("busy_after_start", busy, 1);
      checkOutput("cpu_rst_after_start", cpu_rst, 1);
      checkOutput("done_after_start", done, 0);
      for (int i = 0; i < nwords; i++) begin
         if (i >= present_n) return;
         @(negedge clk);
         fs_data = image[i];
         fs_eof  = (i == eof_at);
         fs_busy = 1'b0;
         if (i == nwords - 1) return;
         guard = 0;
         while (!fs_next_data && busy && guard < 20) begin
            @(negedge clk);
            guard++;
         end
         if (!busy) return;
         if (!fs_next_data) begin
            total++;
            bad++;
            $display("[TB] FAIL next_data_wait: observed=none expected=fs_next_data within 20 cycles");
            return;
         end
         fs_busy = 1'b1;
         fs_eof  = 1'b0;
      end
   endtask

   task automatic waitEnd(input int limit);
      int n;
      n = 0;
      while (busy && n < limit) begin
         @(negedge clk);
         n++;
      end
      checkOutput("load_finished", busy, 0);
   endtask

   task automatic setValid3(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c, input logic [31:0] sum);
      image[0] = MAGIC; image[1] = 32'd3;
      image[2] = a; image[3] = b; image[4] = c; image[5] = sum;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; fs_busy = 1'b1; fs_data = '0; fs_eof = 1'b0;
      fs_file_not_found = 1'b0; fs_err = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_error", error_code, 0);
      checkOutput("rst_words", words_loaded, 0);
      checkOutput("rst_cpu_rst", cpu_rst, 1);
      checkOutput("rst_fs_start", fs_start, 0);
      checkOutput("rst_next", fs_next_data, 0);
      checkOutput("rst_mem_we", mem_we, 0);
      checkOutput("rst_mem_addr", mem_addr, 0);
      checkOutput("rst_mem_wdata", mem_wdata, 0);
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] valid image, payload {1,2,3}");
      setValid3(32'd1, 32'd2, 32'd3, 32'd6);
      we_base = we_count;
      applyStimulus(6, 6, -1);
      waitEnd(40);
      checkOutput("valid_done", done, 1);
      checkOutput("valid_cpu_rst", cpu_rst, 0);
      checkOutput("valid_error", error_code, 0);
      checkOutput("valid_words", words_loaded, 3);
      checkOutput("valid_we_count", we_count - we_base, 3);
      checkOutput("valid_mem2", tb_mem[2], 1);
      checkOutput("valid_mem3", tb_mem[3], 2);
      checkOutput("valid_mem4", tb_mem[4], 3);

      $display("[TB] bad magic");
      image[0] = 32'hDEADBEEF;
      we_base = we_count;
      applyStimulus(6, 6, -1);
      waitEnd(40);
      checkOutput("magic_error", error_code, 3);
      checkOutput("magic_we_count", we_count - we_base, 0);
      checkOutput("magic_cpu_rst", cpu_rst, 1);
      checkOutput("magic_done", done, 0);

      $display("[TB] zero length");
      image[0] = MAGIC; image[1] = 32'd0;
      applyStimulus(6, 6, -1);
      waitEnd(40);
      checkOutput("len0_error", error_code, 4);

      $display("[TB] length one past maximum");
      image[1] = 32'd9;
      applyStimulus(6, 6, -1);
      waitEnd(40);
      checkOutput("len9_error", error_code, 4);

      $display("[TB] maximum length 8, address wrap from base 2");
      image[0] = MAGIC; image[1] = 32'd8;
      for (int k = 0; k < 8; k++) image[2 + k] = 32'(k + 1);
      image[10] = 32'd36;
      we_base = we_count;
      applyStimulus(11, 11, -1);
      waitEnd(80);
      checkOutput("max_done", done, 1);
      checkOutput("max_words", words_loaded, 8);
      checkOutput("max_we_count", we_count - we_base, 8);
      checkOutput("max_mem2", tb_mem[2], 1);
      checkOutput("max_mem0", tb_mem[0], 7);
      checkOutput("max_mem1", tb_mem[1], 8);

      $display("[TB] eof with second payload word");
      setValid3(32'd1, 32'd2, 32'd3, 32'd6);
      we_base = we_count;
      applyStimulus(6, 6, 3);
      waitEnd(40);
      checkOutput("eof_error", error_code, 5);
      checkOutput("eof_words", words_loaded, 2);
      checkOutput("eof_we_count", we_count - we_base, 2);

      $display("[TB] wrong checksum");
      setValid3(32'd1, 32'd2, 32'd3, 32'd7);
      applyStimulus(6, 6, -1);
      waitEnd(40);
      checkOutput("sum_error", error_code, 6);
      checkOutput("sum_done", done, 0);
      checkOutput("sum_words", words_loaded, 3);

      $display("[TB] checksum wraps");
      image[0] = MAGIC; image[1] = 32'd2;
      image[2] = 32'hFFFFFFFF; image[3] = 32'd2; image[4] = 32'd1;
      applyStimulus(5, 5, -1);
      waitEnd(40);
      checkOutput("wrap_done", done, 1);
      checkOutput("wrap_error", error_code, 0);

      $display("[TB] file not found");
      applyStimulus(5, 0, -1);
      fs_file_not_found = 1'b1;
      waitEnd(10);
      fs_file_not_found = 1'b0;
      checkOutput("fnf_error", error_code, 1);
      checkOutput("fnf_cpu_rst", cpu_rst, 1);

      $display("[TB] wrapper error");
      applyStimulus(5, 0, -1);
      fs_err = 1'b1;
      waitEnd(10);
      fs_err = 1'b0;
      checkOutput("fserr_error", error_code, 2);

      $display("[TB] fs_busy stuck high");
      applyStimulus(5, 0, -1);
      waitEnd(100);
      checkOutput("timeout_error", error_code, 7);

      $display("[TB] reset mid-payload");
      setValid3(32'd1, 32'd2, 32'd3, 32'd6);
      applyStimulus(6, 4, -1);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_error", error_code, 0);
      checkOutput("abort_words", words_loaded, 0);
      checkOutput("abort_cpu_rst", cpu_rst, 1);
      checkOutput("abort_mem_we", mem_we, 0);
      checkOutput("abort_mem_addr", mem_addr, 0);
      checkOutput("abort_next", fs_next_data, 0);
      rst = 1'b0;
      we_base = we_count;
      repeat (5) @(negedge clk);
      checkOutput("abort_no_writes", we_count - we_base, 0);

      $display("[TB] reload after reset");
      setValid3(32'd10, 32'd20, 32'd30, 32'd60);
      we_base = we_count;
      applyStimulus(6, 6, -1);
      waitEnd(40);
      checkOutput("reload_done", done, 1);
      checkOutput("reload_we_count", we_count - we_base, 3);
      checkOutput("reload_mem2", tb_mem[2], 10);
      checkOutput("reload_mem4", tb_mem[4], 30);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
